// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: sequential step, conditional branches, jal and jalr.
// Define FETCH_MISALIGN_CHECK_EN to reject jump/branch targets that are not 4-byte aligned.
module fetch_pc_gen #(
  parameter int unsigned            XLEN      = 32,
  parameter logic [XLEN-1:0]        RESET_VEC = 32'h0000_0000,
  parameter int unsigned            STEP      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_en,
  input  logic [2:0]      br_funct,
  input  logic [XLEN-1:0] br_a,
  input  logic [XLEN-1:0] br_b,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_pc,
  output logic            redirect,
  output logic            misalign
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic            cmp_result;
  logic            br_taken;

  logic [XLEN-1:0] target;
  logic            take;
  logic            do_link;
  logic            bad_align;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] next_link_pc;
  logic            next_redirect;

  assign seq_pc      = pc + XLEN'(STEP);
  assign rel_target  = pc + imm;
  assign jalr_sum    = rs + imm;
  assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

  always_comb begin
    cmp_result = 1'b0;
    case (br_funct)
      3'b000:  cmp_result = (br_a == br_b);
      3'b001:  cmp_result = (br_a != br_b);
      3'b100:  cmp_result = ($signed(br_a) <  $signed(br_b));
      3'b101:  cmp_result = ($signed(br_a) >= $signed(br_b));
      3'b110:  cmp_result = (br_a <  br_b);
      3'b111:  cmp_result = (br_a >= br_b);
      default: cmp_result = 1'b0;
    endcase
  end

  assign br_taken = br_en & cmp_result;

  // jalr outranks jal, and either one masks any concurrent branch.
  always_comb begin
    target  = seq_pc;
    take    = 1'b0;
    do_link = 1'b0;
    if (jalr) begin
      target  = jalr_target;
      take    = 1'b1;
      do_link = 1'b1;
    end else if (jal) begin
      target  = rel_target;
      take    = 1'b1;
      do_link = 1'b1;
    end else if (br_taken) begin
      target  = rel_target;
      take    = 1'b1;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bad_align = take & (target[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    next_pc       = seq_pc;
    next_link_pc  = link_pc;
    next_redirect = 1'b0;
    if (take && !bad_align) begin
      next_pc       = target;
      next_redirect = 1'b1;
      if (do_link) begin
        next_link_pc = seq_pc;
      end
    end
  end

  // A stall freezes every register, including any pending pulse, so it is not lost.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_VEC;
      link_pc  <= '0;
      redirect <= 1'b0;
    end else if (!stall) begin
      pc       <= next_pc;
      link_pc  <= next_link_pc;
      redirect <= next_redirect;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      misalign <= 1'b0;
    end else if (!stall) begin
      misalign <= bad_align;
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen; state changes on the falling edge,
// inputs are driven and outputs sampled 1 time unit after each falling edge.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_en;
  logic [2:0]  br_funct;
  logic [31:0] br_a;
  logic [31:0] br_b;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] rs;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        redirect;
  logic        misalign;

  int compared   = 0;
  int mismatched = 0;

  fetch_pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0000), .STEP(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_en(br_en), .br_funct(br_funct),
    .br_a(br_a), .br_b(br_b), .jal(jal), .jalr(jalr), .imm(imm), .rs(rs),
    .pc(pc), .link_pc(link_pc), .redirect(redirect), .misalign(misalign)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_link,
                           input logic e_red, input logic e_mis);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".link"}, link_pc, e_link);
    check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, e_red});
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_en = 0; br_funct = 3'b000; br_a = 0; br_b = 0;
    jal = 0; jalr = 0; imm = 0; rs = 0;
  endtask

  task automatic set_pc(input logic [31:0] value);
    idle();
    jalr = 1; rs = value;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_all("async_reset", 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    check_all("after_release", 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); check_all("seq1", 32'h4, 32'h0, 1'b0, 1'b0);
    tick(); check_all("seq2", 32'h8, 32'h0, 1'b0, 1'b0);
    tick(); check_all("seq3", 32'hC, 32'h0, 1'b0, 1'b0);

    // jalr from 0xC to 0x10, link = 0x10
    jalr = 1; rs = 32'h10;
    tick(); check_all("jalr_to_10", 32'h10, 32'h10, 1'b1, 1'b0);
    idle();

    // signed less-than taken: -1 < 1
    br_en = 1; br_funct = 3'b100; br_a = 32'hFFFF_FFFF; br_b = 32'h1; imm = 32'h20;
    tick(); check_all("blt_taken", 32'h30, 32'h10, 1'b1, 1'b0);
    idle();
    tick(); check_all("redirect_drop", 32'h34, 32'h10, 1'b0, 1'b0);

    set_pc(32'h10);
    check_all("reload_10", 32'h10, 32'h38, 1'b1, 1'b0);
    // unsigned less-than not taken: 0xFFFFFFFF !< 1
    br_en = 1; br_funct = 3'b110; br_a = 32'hFFFF_FFFF; br_b = 32'h1; imm = 32'h20;
    tick(); check_all("bltu_not_taken", 32'h14, 32'h38, 1'b0, 1'b0);

    br_funct = 3'b000; br_a = 32'h5; br_b = 32'h5; imm = 32'h8;
    tick(); check_all("beq_taken", 32'h1C, 32'h38, 1'b1, 1'b0);
    br_funct = 3'b011;
    tick(); check_all("funct011_not_taken", 32'h20, 32'h38, 1'b0, 1'b0);
    br_funct = 3'b101; br_a = 32'hFFFF_FFFF; br_b = 32'h1; imm = 32'h40;
    tick(); check_all("bge_not_taken", 32'h24, 32'h38, 1'b0, 1'b0);
    br_funct = 3'b110; br_a = 32'h1; br_b = 32'hFFFF_FFFF; imm = 32'h10;
    tick(); check_all("bltu_taken", 32'h34, 32'h38, 1'b1, 1'b0);
    br_en = 0; br_funct = 3'b000; br_a = 0; br_b = 0;
    tick(); check_all("br_en_low", 32'h38, 32'h38, 1'b0, 1'b0);

    set_pc(32'h40);
    check_all("reload_40", 32'h40, 32'h3C, 1'b1, 1'b0);
    jal = 1; imm = 32'hFFFF_FFF0;
    tick(); check_all("jal_back", 32'h30, 32'h44, 1'b1, 1'b0);
    idle();
    jalr = 1; rs = 32'h101; imm = 32'h0;
    tick(); check_all("jalr_bit0", 32'h100, 32'h34, 1'b1, 1'b0);
    idle();

    // jal + jalr + taken branch together: jalr wins
    jalr = 1; jal = 1; rs = 32'h200; imm = 32'h4;
    br_en = 1; br_funct = 3'b000; br_a = 32'h7; br_b = 32'h7;
    tick(); check_all("jalr_priority", 32'h204, 32'h104, 1'b1, 1'b0);
    idle();
    tick(); check_all("plain_step", 32'h208, 32'h104, 1'b0, 1'b0);

    stall = 1; jal = 1; imm = 32'h40;
    tick(); check_all("stall1", 32'h208, 32'h104, 1'b0, 1'b0);
    tick(); check_all("stall2", 32'h208, 32'h104, 1'b0, 1'b0);
    idle();
    tick(); check_all("stall_release", 32'h20C, 32'h104, 1'b0, 1'b0);

    set_pc(32'h20);
    check_all("reload_20", 32'h20, 32'h210, 1'b1, 1'b0);
    jal = 1; imm = 32'h6;
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    check_all("misalign_jal", 32'h24, 32'h210, 1'b0, 1'b1);
    idle();
    tick(); check_all("misalign_drop", 32'h28, 32'h210, 1'b0, 1'b0);
`else
    check_all("unaligned_jal", 32'h26, 32'h24, 1'b1, 1'b0);
    idle();
    tick(); check_all("unaligned_next", 32'h2A, 32'h24, 1'b0, 1'b0);
`endif

    set_pc(32'hFFFF_FFFC);
    tick(); check("wrap.pc", pc, 32'h0);
    check("wrap.redirect", {31'd0, redirect}, 32'h0);
    tick(); check("post_wrap.pc", pc, 32'h4);

    // reset pulse between edges acts immediately, then stepping resumes from RESET_VEC
    #1 rst = 1'b0;
    #1 check_all("mid_reset", 32'h0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    tick(); check_all("reset_resume", 32'h4, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
